// File: rtl/clk_enable_gen_multi.sv
// ----------------------------------------------------------------------------
// clk_enable_gen_multi
//
// Multi-channel programmable clock-enable generator. Each of NUM_CH channels
// divides clk10 by a runtime-loadable divisor and produces a one-cycle tick,
// a 50%-duty square wave (toggling on every tick) and a one-shot done flag.
//
// Ports:
//   clk10     in   system clock, all logic on rising edge
//   reset     in   asynchronous, active-high reset
//   wr_en     in   divisor write strobe (one write per cycle)
//   wr_sel    in   [SEL_W]  channel index for the write
//   wr_div    in   [CNT_W]  new divisor value
//   run       in   [NUM_CH] per-channel run request (level)
//   oneshot   in   [NUM_CH] 1 = single tick then stop, 0 = periodic
//   sync_clr  in   realign the phase of all running channels
//   tick      out  [NUM_CH] one-cycle enable pulse
//   sq_out    out  [NUM_CH] square wave, toggles on each tick
//   done      out  [NUM_CH] one-shot complete flag
// ----------------------------------------------------------------------------
module clk_enable_gen_multi #(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 26,
  parameter int          SEL_W       = 2,
  parameter int unsigned DEFAULT_DIV = 10000000
) (
  input  logic              clk10,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [CNT_W-1:0]  wr_div,
  input  logic [NUM_CH-1:0] run,
  input  logic [NUM_CH-1:0] oneshot,
  input  logic              sync_clr,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq_out,
  output logic [NUM_CH-1:0] done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [CNT_W-1:0]  act_q   [NUM_CH];
  logic [CNT_W-1:0]  act_d   [NUM_CH];
  logic [CNT_W-1:0]  shd_q   [NUM_CH];
  logic [CNT_W-1:0]  shd_d   [NUM_CH];
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] sq_q,   sq_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] term;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // NOTE: every variable gets a default before any branch, so no path
      // through this block leaves a value unassigned and no latch is inferred.
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      act_d[i]   = act_q[i];
      tick_d[i]  = 1'b0;
      sq_d[i]    = sq_q[i];
      done_d[i]  = done_q[i];

      // Comparing against the loop index also discards wr_sel >= NUM_CH.
      // shd_d is the shadow including a same-cycle write, so every reload
      // below sees a write that lands on the same edge.
      shd_d[i] = (wr_en && (int'(wr_sel) == i)) ? wr_div : shd_q[i];

      // An active divisor of 0 can only appear through sync_clr loading a
      // zero shadow; treating it as terminal lets the channel drop to IDLE
      // instead of counting through the whole counter range.
      term[i] = (act_q[i] <= ONE) || (cnt_q[i] == act_q[i] - ONE);

      unique case (state_q[i])
        ST_IDLE: begin
          cnt_d[i]  = '0;
          sq_d[i]   = 1'b0;
          done_d[i] = 1'b0;
          if (run[i] && (shd_d[i] != '0)) begin
            state_d[i] = ST_RUN;
            act_d[i]   = shd_d[i];
          end
        end
        ST_RUN: begin
          if (sync_clr) begin
            cnt_d[i] = '0;
            sq_d[i]  = 1'b0;
            act_d[i] = shd_d[i];
          end else if (!run[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
            sq_d[i]    = 1'b0;
          end else if (term[i]) begin
            cnt_d[i]  = '0;
            tick_d[i] = 1'b1;
            act_d[i]  = shd_d[i];
            if (oneshot[i]) begin
              state_d[i] = ST_DONE;
              sq_d[i]    = ~sq_q[i];
              done_d[i]  = 1'b1;
            end else if (shd_d[i] == '0) begin
              // Final tick of a channel whose divisor was cleared.
              state_d[i] = ST_IDLE;
              sq_d[i]    = 1'b0;
            end else begin
              sq_d[i] = ~sq_q[i];
            end
          end else begin
            cnt_d[i] = cnt_q[i] + ONE;
          end
        end
        ST_DONE: begin
          cnt_d[i]  = '0;
          done_d[i] = 1'b1;
          if (!run[i]) begin
            state_d[i] = ST_IDLE;
            done_d[i]  = 1'b0;
            sq_d[i]    = 1'b0;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
          sq_d[i]    = 1'b0;
          done_d[i]  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk10 or posedge reset) begin
    if (reset) begin
      // NOTE: these arrays are a handful of per-channel flops, not a RAM, so
      // resetting every entry is cheap and required for a known start state.
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        act_q[i]   <= DEF_DIV;
        shd_q[i]   <= DEF_DIV;
      end
      tick_q <= '0;
      sq_q   <= '0;
      done_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // computed before this edge, independent of statement order.
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        act_q[i]   <= act_d[i];
        shd_q[i]   <= shd_d[i];
      end
      tick_q <= tick_d;
      sq_q   <= sq_d;
      done_q <= done_d;
    end
  end

  assign tick   = tick_q;
  assign sq_out = sq_q;
  assign done   = done_q;

endmodule

// File: tb/tb_clk_enable_gen_multi.sv
// ----------------------------------------------------------------------------
// tb_clk_enable_gen_multi
//
// Self-checking bench for clk_enable_gen_multi. Each scenario pushes the
// cycle numbers at which it expects ticks onto a scoreboard when it drives
// the stimulus; a per-cycle monitor inside step() pops matching entries,
// reports ticks nobody expected and expected ticks that never came.
// cyc counts rising edges; outputs are sampled on the falling edge after
// edge cyc, so a run request driven while cyc == c is sampled at edge c+1.
// ----------------------------------------------------------------------------
module tb_clk_enable_gen_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 26;
  localparam int SEL_W  = 2;
  localparam int DEF    = 12;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  logic              clk10;
  logic              reset;
  logic              wr_en;
  logic [SEL_W-1:0]  wr_sel;
  logic [CNT_W-1:0]  wr_div;
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] oneshot;
  logic              sync_clr;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq_out;
  logic [NUM_CH-1:0] done;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  clk_enable_gen_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .SEL_W       (SEL_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk10    (clk10),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_div   (wr_div),
    .run      (run),
    .oneshot  (oneshot),
    .sync_clr (sync_clr),
    .tick     (tick),
    .sq_out   (sq_out),
    .done     (done)
  );

  initial clk10 = 1'b0;
  always #5 clk10 = ~clk10;

  always @(posedge clk10) cyc = cyc + 1;

  task automatic push_tick(input int ch, input int at);
    exp_t e;
    e.ch  = ch;
    e.cyc = at;
    sb_q.push_back(e);
  endtask

  // Advance n cycles, scoring every tick against the scoreboard.
  task automatic step(input int n);
    int idx;
    for (int s = 0; s < n; s++) begin
      @(posedge clk10);
      @(negedge clk10);
      for (int c = 0; c < NUM_CH; c++) begin
        if (tick[c] === 1'b1) begin
          idx = -1;
          foreach (sb_q[j])
            if (idx < 0 && sb_q[j].ch == c && sb_q[j].cyc == cyc) idx = j;
          n_checks++;
          if (idx < 0) begin
            n_fail++;
            $display("FAIL unexpected_tick ch%0d: tick=1 at cycle %0d, required 0", c, cyc);
          end else begin
            sb_q.delete(idx);
          end
        end
      end
      for (int j = sb_q.size() - 1; j >= 0; j--) begin
        if (sb_q[j].cyc <= cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL missing_tick ch%0d: tick=0 at cycle %0d, required 1",
                   sb_q[j].ch, sb_q[j].cyc);
          sb_q.delete(j);
        end
      end
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic write_div(input int ch, input int div);
    wr_en  = 1'b1;
    wr_sel = SEL_W'(ch);
    wr_div = CNT_W'(div);
    step(1);
    wr_en  = 1'b0;
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: %0d expected ticks outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_div = '0;
    run = '0; oneshot = '0; sync_clr = 1'b0;
    repeat (3) @(negedge clk10);
    n_checks++;
    if ({tick, sq_out, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: tick=%b sq=%b done=%b, required all 0", tick, sq_out, done);
    end
    reset = 1'b0;
    step(20);
    n_checks++;
    if ({tick, sq_out, done} !== '0) begin
      n_fail++;
      $display("FAIL idle_outputs: tick=%b sq=%b done=%b, required all 0", tick, sq_out, done);
    end
  endtask

  task automatic test_periodic;
    int k;
    write_div(0, 5);
    run[0] = 1'b1;
    k = cyc + 1;
    push_tick(0, k + 5); push_tick(0, k + 10); push_tick(0, k + 15);
    step_to(k + 4);
    n_checks++;
    if (sq_out[0] !== 1'b0) begin n_fail++; $display("FAIL sq_before_tick: sq=%b, required 0", sq_out[0]); end
    step_to(k + 5);
    n_checks++;
    if (sq_out[0] !== 1'b1) begin n_fail++; $display("FAIL sq_tick1: sq=%b, required 1", sq_out[0]); end
    step_to(k + 10);
    n_checks++;
    if (sq_out[0] !== 1'b0) begin n_fail++; $display("FAIL sq_tick2: sq=%b, required 0", sq_out[0]); end
    step_to(k + 15);
    n_checks++;
    if (sq_out[0] !== 1'b1) begin n_fail++; $display("FAIL sq_tick3: sq=%b, required 1", sq_out[0]); end
    n_checks++;
    if (sq_out[3:1] !== 3'b000 || done !== '0) begin
      n_fail++;
      $display("FAIL other_channels: sq=%b done=%b, required sq[3:1]=000 done=0000", sq_out, done);
    end
    step_to(k + 16);
    run[0] = 1'b0;
    step(1);
    n_checks++;
    if (sq_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_clears: sq=%b tick=%b, required 0 0", sq_out[0], tick[0]);
    end
    check_drained("periodic");
  endtask

  task automatic test_div1_reload;
    int k, w;
    write_div(1, 1);
    run[1] = 1'b1;
    k = cyc + 1;
    for (int j = 1; j <= 6; j++) push_tick(1, k + j);
    step_to(k + 5);
    w = cyc + 1;
    push_tick(1, w + 3); push_tick(1, w + 6); push_tick(1, w + 9);
    write_div(1, 3);
    step_to(w + 9);
    run[1] = 1'b0;
    step(1);
    check_drained("div1_reload");
  endtask

  task automatic test_oneshot;
    int k;
    write_div(2, 4);
    oneshot[2] = 1'b1;
    run[2] = 1'b1;
    k = cyc + 1;
    push_tick(2, k + 4);
    step_to(k + 3);
    n_checks++;
    if (done[2] !== 1'b0) begin n_fail++; $display("FAIL done_early: done=%b, required 0", done[2]); end
    step_to(k + 5);
    n_checks++;
    if (done[2] !== 1'b1) begin n_fail++; $display("FAIL done_set: done=%b, required 1", done[2]); end
    step_to(k + 8);
    n_checks++;
    if (done[2] !== 1'b1 || sq_out[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL done_hold: done=%b sq=%b, required 1 1", done[2], sq_out[2]);
    end
    run[2] = 1'b0;
    step(1);
    n_checks++;
    if (done[2] !== 1'b0 || sq_out[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL done_clear: done=%b sq=%b, required 0 0", done[2], sq_out[2]);
    end
    run[2] = 1'b1;
    k = cyc + 1;
    push_tick(2, k + 4);
    step_to(k + 5);
    n_checks++;
    if (done[2] !== 1'b1) begin n_fail++; $display("FAIL done_rearm: done=%b, required 1", done[2]); end
    run[2] = 1'b0;
    oneshot[2] = 1'b0;
    step(1);
    check_drained("oneshot");
  endtask

  task automatic test_sync_clr;
    int s, s2;
    write_div(0, 8);
    write_div(3, 8);
    run[0] = 1'b1;
    step(3);
    run[3] = 1'b1;
    step(1);
    sync_clr = 1'b1;
    s = cyc + 1;
    push_tick(0, s + 8); push_tick(3, s + 8);
    step(1);
    sync_clr = 1'b0;
    step_to(s + 8);
    n_checks++;
    if (sq_out[0] !== 1'b1 || sq_out[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_sq: sq0=%b sq3=%b, required 1 1", sq_out[0], sq_out[3]);
    end
    sync_clr = 1'b1;
    wr_en = 1'b1; wr_sel = 2'd3; wr_div = CNT_W'(2);
    s2 = cyc + 1;
    push_tick(0, s2 + 8);
    for (int j = 2; j <= 8; j += 2) push_tick(3, s2 + j);
    step(1);
    sync_clr = 1'b0;
    wr_en = 1'b0;
    step_to(s2 + 8);
    run[0] = 1'b0;
    run[3] = 1'b0;
    step(1);
    check_drained("sync_clr");
  endtask

  task automatic test_async_reset;
    int k;
    oneshot[2] = 1'b1;
    run[2] = 1'b1;
    k = cyc + 1;
    push_tick(2, k + 4);
    step_to(k + 5);
    write_div(0, 10);
    run[0] = 1'b1;
    k = cyc + 1;
    step_to(k + 3);
    n_checks++;
    if (done[2] !== 1'b1 || sq_out[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: done=%b sq=%b, required 1 1", done[2], sq_out[2]);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({tick, sq_out, done} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: tick=%b sq=%b done=%b, required all 0", tick, sq_out, done);
    end
    run = '0;
    oneshot = '0;
    step(2);
    reset = 1'b0;
    run[0] = 1'b1;
    run[1] = 1'b1;
    k = cyc + 1;
    push_tick(0, k + DEF); push_tick(0, k + 2 * DEF);
    push_tick(1, k + DEF); push_tick(1, k + 2 * DEF);
    step_to(k + 2 * DEF);
    run = '0;
    step(1);
    check_drained("async_reset");
  endtask

  task automatic test_div_zero;
    int k;
    write_div(1, 6);
    run[1] = 1'b1;
    k = cyc + 1;
    push_tick(1, k + 6); push_tick(1, k + 12);
    step_to(k + 8);
    write_div(1, 0);
    step_to(k + 42);
    n_checks++;
    if (sq_out[1] !== 1'b0 || done[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL div0_idle: sq=%b done=%b, required 0 0", sq_out[1], done[1]);
    end
    run[1] = 1'b0;
    step(1);
    run[1] = 1'b1;
    step(50);
    run[1] = 1'b0;
    step(1);
    check_drained("div_zero");
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_div1_reload();
    test_oneshot();
    test_sync_clr();
    test_async_reset();
    test_div_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
